wallace_mac_acc: RTL and testbench

WALLACE_MAC_ACC -- requirements
Module: wallace_mac_acc

---
 rtl/wallace_mac_acc.sv | 95 +++++++++
 tb/tb_wallace_mac_acc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mac_acc.sv
// ============================================================================
// Module   : wallace_mac_acc
// Purpose  : Length-counted accumulator for 17-bit Wallace multiplier products
//            with ready/valid handshakes and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wallace_mac_acc #(
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       len,
   input  logic [16:0]      prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_remaining;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;
   logic             w_accept;
   logic [ACC_W:0]   w_sum;

   assign w_accept = (r_state == ACC) && prod_valid;
   // One extra bit catches the carry out of the accumulator MSB.
   assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(prod);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = (len != 8'd0) ? ACC : DONE;
            end
         end
         ACC: begin
            if (w_accept && (r_remaining == 8'd1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (acc_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_remaining <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == IDLE) && start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= len;
         end else if (w_accept) begin
            r_acc       <= w_sum[ACC_W-1:0];
            r_ovf       <= r_ovf | w_sum[ACC_W];
            r_remaining <= r_remaining - 8'd1;
         end
      end
   end

   // Handshake outputs are pure state decodes, so no input reaches an output.
   assign prod_ready = (r_state == ACC);
   assign acc_valid  = (r_state == DONE);
   assign busy       = (r_state != IDLE);
   assign acc_out    = r_acc;
   assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_wallace_mac_acc.sv
// ============================================================================
// Module   : tb_wallace_mac_acc
// Purpose  : Self-checking bench: directed table, corner sequences, random runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wallace_mac_acc;

   localparam int C_ACC_W = 24;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [7:0]         len;
   logic [16:0]        prod;
   logic               prod_valid;
   logic               prod_ready;
   logic [C_ACC_W-1:0] acc_out;
   logic               acc_valid;
   logic               acc_ready;
   logic               overflow;
   logic               busy;

   wallace_mac_acc #(.ACC_W(C_ACC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .acc_out    (acc_out),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .overflow   (overflow),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int n_acc = 0;
   int acc_base;
   logic [16:0] pq [256];

   always @(posedge clk) begin
      if (rst_n && prod_valid && prod_ready) n_acc <= n_acc + 1;
   end

   typedef struct {
      int     len;
      int     prod;
      int     gap;
      int     hold;
      longint exp_acc;
      bit     exp_ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_start(input int l);
      @(negedge clk);
      start = 1'b1;
      len   = 8'(l);
      acc_base = n_acc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [16:0] p, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         prod_valid = 1'b0;
      end
      t = 0;
      do begin
         @(negedge clk);
         prod_valid = 1'b1;
         prod       = p;
         t++;
      end while (!prod_ready && t < 50);
      if (t >= 50) chk("prod_ready_timeout", 0, 1);
   endtask

   // Entered on the negedge right after the last accept (or after start for len=0).
   task automatic finish_chk(input longint exp_acc, input bit exp_ovf, input int hold, input int n);
      prod_valid = 1'b1;
      prod       = 17'h1234;
      chk("acc_valid_latency", acc_valid, 1);
      chk("acc_out", acc_out, exp_acc);
      chk("overflow", overflow, exp_ovf);
      chk("busy_done", busy, 1);
      chk("prod_ready_done", prod_ready, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("acc_valid_hold", acc_valid, 1);
         chk("acc_out_hold", acc_out, exp_acc);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready  = 1'b0;
      prod_valid = 1'b0;
      chk("acc_valid_after", acc_valid, 0);
      chk("busy_after", busy, 0);
      chk("acc_out_after", acc_out, exp_acc);
      chk("overflow_after", overflow, exp_ovf);
      chk("accept_count", n_acc - acc_base, n);
   endtask

   task automatic run(input int l, input int gap, input int hold, input longint exp_acc, input bit exp_ovf);
      do_start(l);
      for (int i = 0; i < l; i++) send(pq[i], i % (gap + 1));
      if (l > 0) @(negedge clk);
      finish_chk(exp_acc, exp_ovf, hold, l);
   endtask

   initial begin
      longint total;
      int     l;

      vecs[0] = '{len: 4,   prod: 10,      gap: 3, hold: 5, exp_acc: 40,       exp_ovf: 1'b0};
      vecs[1] = '{len: 0,   prod: 0,       gap: 0, hold: 2, exp_acc: 0,        exp_ovf: 1'b0};
      vecs[2] = '{len: 129, prod: 'h1FFFF, gap: 0, hold: 1, exp_acc: 130943,   exp_ovf: 1'b1};
      vecs[3] = '{len: 1,   prod: 'h1FFFF, gap: 2, hold: 0, exp_acc: 131071,   exp_ovf: 1'b0};
      vecs[4] = '{len: 128, prod: 'h1FFFF, gap: 1, hold: 0, exp_acc: 16777088, exp_ovf: 1'b0};
      vecs[5] = '{len: 255, prod: 'h1FFFF, gap: 0, hold: 0, exp_acc: 16645889, exp_ovf: 1'b1};

      rst_n = 1'b0; start = 1'b0; len = 8'd0; prod = 17'd0;
      prod_valid = 1'b0; acc_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_acc_out", acc_out, 0);
      chk("rst_acc_valid", acc_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prod_ready", prod_ready, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;

      // Basic run with distinct back-to-back products
      pq[0] = 17'd65025; pq[1] = 17'd1; pq[2] = 17'd100;
      run(3, 0, 0, 65126, 1'b0);

      foreach (vecs[k]) begin
         for (int i = 0; i < vecs[k].len; i++) pq[i] = 17'(vecs[k].prod);
         run(vecs[k].len, vecs[k].gap, vecs[k].hold, vecs[k].exp_acc, vecs[k].exp_ovf);
      end

      // Reset mid-run, with start held during reset
      do_start(5);
      send(17'd3, 0);
      send(17'd4, 0);
      @(negedge clk);
      prod_valid = 1'b0;
      rst_n = 1'b0;
      start = 1'b1;
      len   = 8'd3;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_acc_out", acc_out, 0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      chk("midrst_acc_valid", acc_valid, 0);
      chk("midrst_prod_ready", prod_ready, 0);
      chk("midrst_overflow", overflow, 0);
      @(negedge clk);
      chk("midrst_idle_after", busy, 0);

      // Start ignored during ACC and in the handoff cycle
      do_start(2);
      prod_valid = 1'b1; prod = 17'd7; start = 1'b1; len = 8'd9;
      @(negedge clk);
      prod = 17'd8;
      @(negedge clk);
      prod_valid = 1'b0;
      chk("ign_acc_valid", acc_valid, 1);
      chk("ign_acc_out", acc_out, 15);
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      start     = 1'b0;
      chk("ign_handoff_busy", busy, 0);
      chk("ign_handoff_valid", acc_valid, 0);
      chk("ign_acc_out_held", acc_out, 15);
      chk("ign_accepts", n_acc - acc_base, 2);

      // Random runs checked against a plain-arithmetic model
      for (int r = 0; r < 20; r++) begin
         l = (r % 5 == 4) ? $urandom_range(120, 255) : $urandom_range(0, 30);
         total = 0;
         for (int i = 0; i < l; i++) begin
            pq[i] = (r % 5 == 4) ? 17'($urandom_range(100000, 131071)) : 17'($urandom);
            total += longint'(pq[i]);
         end
         run(l, r % 3, $urandom_range(0, 3),
             total % (longint'(1) << C_ACC_W), total >= (longint'(1) << C_ACC_W));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
